ball_vertical_bounce: RTL and testbench

- Produces the vertical direction bit that drives the vertical ball counter's direction input.
- Watches the ball's vertical video signal line by line during the active frame.
- Flips direction when the ball touches the first or last visible line, decided once per frame at the start of vertical blanking.
- Sits between the VGA timing generator and the vertical ball counter.

---
 rtl/ball_vertical_bounce.sv | 177 +++++++++++++++++
 tb/tb_ball_vertical_bounce.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_vertical_bounce.sv
// ball_vertical_bounce
//
// Produces the vertical direction bit for the vertical ball counter. During the
// active frame it watches the ball's vertical video, one sample per line. At the
// start of vertical blanking it decides whether the ball touched the first or
// last visible line, and flips direction when it did.
//
// Ports:
//   i_Clk        pixel clock
//   i_Reset      synchronous, active-high reset
//   i_HReset     one-cycle line-start pulse
//   i_VBlank     high during vertical blanking
//   i_BallVideo  ball vertical video, high on lines the ball occupies
//   i_Serve      one-cycle pulse, forces p_INIT_DIR at the next frame decision
//   o_VDir       current direction (1 = up, 0 = down)
//   o_Bounce     one-cycle pulse when o_VDir flips
//   o_FrameErr   one-cycle pulse when a frame ended with a wrong line count
module ball_vertical_bounce #(
  parameter int unsigned p_LINES    = 480,
  parameter bit          p_INIT_DIR = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_HReset,
  input  logic i_VBlank,
  input  logic i_BallVideo,
  input  logic i_Serve,
  output logic o_VDir,
  output logic o_Bounce,
  output logic o_FrameErr
);

  localparam int unsigned c_CNT_W = $clog2(p_LINES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_LINE = c_CNT_W'(p_LINES - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_CNT  = c_CNT_W'(p_LINES);

  typedef enum logic [1:0] {
    SYNC,
    WAIT,
    SCAN,
    DECIDE
  } state_t;

  state_t             state, state_nxt;
  logic [c_CNT_W-1:0] line_cnt, line_cnt_nxt;
  logic               vblank_q;
  logic               samp_pend, samp_pend_nxt;
  logic               top_hit, top_hit_nxt;
  logic               bot_hit, bot_hit_nxt;
  logic               serve_pend, serve_pend_nxt;
  logic               vdir_nxt, bounce_nxt, frame_err_nxt;
  logic               vblank_rise;

  assign vblank_rise = i_VBlank & ~vblank_q;

  // Next-state logic. The frame decision is taken on the edge that sees VBlank
  // rise, so that the registered outputs show the result during the single
  // DECIDE cycle. After that, o_VDir stays put for the whole next active frame.
  always_comb begin
    state_nxt      = state;
    line_cnt_nxt   = line_cnt;
    samp_pend_nxt  = samp_pend;
    top_hit_nxt    = top_hit;
    bot_hit_nxt    = bot_hit;
    serve_pend_nxt = serve_pend;
    vdir_nxt       = o_VDir;
    bounce_nxt     = 1'b0;
    frame_err_nxt  = 1'b0;

    case (state)
      // Partial frame after reset: nothing is recorded, so no decision is made.
      SYNC: begin
        line_cnt_nxt  = '0;
        samp_pend_nxt = 1'b0;
        top_hit_nxt   = 1'b0;
        bot_hit_nxt   = 1'b0;
        if (vblank_rise) begin
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        line_cnt_nxt  = '0;
        samp_pend_nxt = 1'b0;
        top_hit_nxt   = 1'b0;
        bot_hit_nxt   = 1'b0;
        if (!i_VBlank) begin
          state_nxt = SCAN;
        end
      end

      SCAN: begin
        if (vblank_rise) begin
          // A sample still pending at this point is dropped.
          state_nxt     = DECIDE;
          samp_pend_nxt = 1'b0;
          if (line_cnt != c_FULL_CNT) begin
            frame_err_nxt = 1'b1;
          end else if (serve_pend) begin
            vdir_nxt       = p_INIT_DIR;
            serve_pend_nxt = 1'b0;
          end else if (top_hit && bot_hit) begin
            // Ball spans the whole screen: keep the current direction.
            vdir_nxt = o_VDir;
          end else if (top_hit && o_VDir) begin
            vdir_nxt   = 1'b0;
            bounce_nxt = 1'b1;
          end else if (bot_hit && !o_VDir) begin
            vdir_nxt   = 1'b1;
            bounce_nxt = 1'b1;
          end
        end else begin
          // The video is sampled one cycle after the line-start pulse. A new
          // pulse in that same cycle re-arms the request, so back-to-back
          // pulses are all counted.
          if (samp_pend) begin
            if (i_BallVideo && (line_cnt == '0)) begin
              top_hit_nxt = 1'b1;
            end
            if (i_BallVideo && (line_cnt == c_LAST_LINE)) begin
              bot_hit_nxt = 1'b1;
            end
            if (line_cnt != c_FULL_CNT) begin
              line_cnt_nxt = line_cnt + 1'b1;
            end
            samp_pend_nxt = 1'b0;
          end
          if (i_HReset && !i_VBlank) begin
            samp_pend_nxt = 1'b1;
          end
        end
      end

      DECIDE: begin
        state_nxt = WAIT;
      end

      default: begin
        state_nxt = SYNC;
      end
    endcase

    // A serve is never lost. One that arrives on or after the decision edge
    // is held over for the next frame.
    if (i_Serve) begin
      serve_pend_nxt = 1'b1;
    end
  end

  // State and output registers. vblank_q keeps tracking VBlank through reset,
  // so that releasing reset during blanking is not seen as a fresh VBlank edge.
  always_ff @(posedge i_Clk) begin
    vblank_q <= i_VBlank;
    if (i_Reset) begin
      state      <= SYNC;
      line_cnt   <= '0;
      samp_pend  <= 1'b0;
      top_hit    <= 1'b0;
      bot_hit    <= 1'b0;
      serve_pend <= 1'b0;
      o_VDir     <= p_INIT_DIR;
      o_Bounce   <= 1'b0;
      o_FrameErr <= 1'b0;
    end else begin
      state      <= state_nxt;
      line_cnt   <= line_cnt_nxt;
      samp_pend  <= samp_pend_nxt;
      top_hit    <= top_hit_nxt;
      bot_hit    <= bot_hit_nxt;
      serve_pend <= serve_pend_nxt;
      o_VDir     <= vdir_nxt;
      o_Bounce   <= bounce_nxt;
      o_FrameErr <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_ball_vertical_bounce.sv
// tb_ball_vertical_bounce
//
// Drives whole frames (blanking, line pulses, ball video) into
// ball_vertical_bounce. A frame-level model predicts the direction and the
// pulses that each frame decision produces.
module tb_ball_vertical_bounce;

  localparam int LINES    = 480;
  localparam bit INIT_DIR = 1'b1;

  logic i_Clk = 1'b0;
  logic i_Reset, i_HReset, i_VBlank, i_BallVideo, i_Serve;
  logic o_VDir, o_Bounce, o_FrameErr;

  int compared   = 0;
  int mismatched = 0;

  // Frame-level reference state: the current direction and the outstanding serve.
  bit modelDir   = INIT_DIR;
  bit modelServe = 1'b0;

  ball_vertical_bounce #(
    .p_LINES   (LINES),
    .p_INIT_DIR(INIT_DIR)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_HReset   (i_HReset),
    .i_VBlank   (i_VBlank),
    .i_BallVideo(i_BallVideo),
    .i_Serve    (i_Serve),
    .o_VDir     (o_VDir),
    .o_Bounce   (o_Bounce),
    .o_FrameErr (o_FrameErr)
  );

  always #5 i_Clk = ~i_Clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic applyStimulus(input bit rst, input bit hres, input bit vbl,
                               input bit vid, input bit srv);
    i_Reset     = rst;
    i_HReset    = hres;
    i_VBlank    = vbl;
    i_BallVideo = vid;
    i_Serve     = srv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic bit inBall(input int line, input int y, input int h);
    return (line >= y) && (line < y + h);
  endfunction

  // One frame: an active period of nLines lines with period clocks per line,
  // followed by VBlank rising and a short blanking interval. The ball
  // occupies lines [y, y+h). serveLine and resetLine give the line at which
  // i_Serve or i_Reset is pulsed (-1 means no pulse). fromSync is set for the
  // partial frame that follows reset.
  task automatic runFrame(input string name, input int nLines, input int y,
                          input int h, input int period, input int serveLine,
                          input int resetLine, input bit fromSync);
    int total, quiet, drift, counted, l;
    bit hres, vid, srv, rst, noDecision, dirStart, topOn, botOn;
    bit eDir, eBounce, eErr;
    quiet      = 0;
    drift      = 0;
    noDecision = fromSync;
    dirStart   = modelDir;

    applyStimulus(0, 0, 0, 0, 0);
    tick();
    total = nLines * period + 2;
    for (int c = 0; c < total; c++) begin
      l    = c / period;
      hres = (c < nLines * period) && (c % period == 0);
      vid  = 1'b0;
      if (c >= 1 && ((c - 1) % period == 0) && ((c - 1) / period < nLines))
        vid = inBall((c - 1) / period, y, h);
      srv = hres && (l == serveLine);
      rst = hres && (l == resetLine);
      applyStimulus(rst, hres, 0, vid, srv);
      tick();
      if (rst) begin
        modelDir   = INIT_DIR;
        modelServe = 1'b0;
        noDecision = 1'b1;
        dirStart   = INIT_DIR;
        checkOutput({name, " reset dir"}, 32'(o_VDir), 32'(INIT_DIR));
        checkOutput({name, " reset pulses"}, 32'({o_Bounce, o_FrameErr}), 32'd0);
      end else begin
        if (o_Bounce || o_FrameErr) quiet++;
        if (o_VDir !== dirStart) drift++;
      end
      if (srv) modelServe = 1'b1;
    end
    checkOutput({name, " active pulses"}, 32'(quiet), 32'd0);
    checkOutput({name, " active dir stable"}, 32'(drift), 32'd0);

    // Model the frame decision from the lines the ball covered.
    eDir    = modelDir;
    eBounce = 1'b0;
    eErr    = 1'b0;
    if (!noDecision) begin
      counted = (nLines < LINES) ? nLines : LINES;
      topOn   = inBall(0, y, h) && (nLines >= 1);
      botOn   = inBall(LINES - 1, y, h) && (nLines >= LINES);
      if (counted != LINES) begin
        eErr = 1'b1;
      end else if (modelServe) begin
        eDir       = INIT_DIR;
        modelServe = 1'b0;
      end else if (topOn && botOn) begin
        eDir = modelDir;
      end else if (topOn && modelDir) begin
        eDir    = 1'b0;
        eBounce = 1'b1;
      end else if (botOn && !modelDir) begin
        eDir    = 1'b1;
        eBounce = 1'b1;
      end
      modelDir = eDir;
    end

    applyStimulus(0, 0, 1, 0, 0);
    tick();
    checkOutput({name, " decide dir"}, 32'(o_VDir), 32'(eDir));
    checkOutput({name, " decide bounce"}, 32'(o_Bounce), 32'(eBounce));
    checkOutput({name, " decide frameerr"}, 32'(o_FrameErr), 32'(eErr));
    tick();
    checkOutput({name, " post pulses"}, 32'({o_Bounce, o_FrameErr}), 32'd0);
    checkOutput({name, " post dir"}, 32'(o_VDir), 32'(eDir));
    tick();
    tick();
  endtask

  initial begin
    int y, h, n, sl, sel, per;
    $display("[TB] start");

    // Reset mid-frame, then a partial frame that must not decide anything.
    applyStimulus(1, 0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("reset dir", 32'(o_VDir), 32'(INIT_DIR));
    checkOutput("reset bounce", 32'(o_Bounce), 32'd0);
    checkOutput("reset frameerr", 32'(o_FrameErr), 32'd0);
    modelDir   = INIT_DIR;
    modelServe = 1'b0;
    runFrame("partial", 100, 0, LINES, 2, -1, -1, 1'b1);
    runFrame("empty", LINES, 0, 0, 2, -1, -1, 1'b0);

    // Edge hits and the direction-dependent ignore rule.
    runFrame("top up", LINES, 0, 16, 2, -1, -1, 1'b0);
    runFrame("bottom down", LINES, 464, 16, 2, -1, -1, 1'b0);
    runFrame("bottom up", LINES, 464, 16, 2, -1, -1, 1'b0);

    // A short frame flags an error and leaves the direction alone.
    runFrame("short", LINES - 1, 0, 16, 2, -1, -1, 1'b0);

    // Serve during a frame restores the initial direction without a bounce.
    runFrame("top again", LINES, 0, 16, 2, -1, -1, 1'b0);
    runFrame("serve", LINES, 0, 16, 2, 240, -1, 1'b0);

    // Reset at line 200 with the top already hit, then a normal frame.
    runFrame("top pre-reset", LINES, 0, 16, 2, -1, -1, 1'b0);
    runFrame("reset mid", LINES, 0, 16, 2, -1, 200, 1'b0);
    runFrame("after reset", LINES, 0, 16, 2, -1, -1, 1'b0);

    // Back-to-back line pulses, and the ball spanning the whole screen.
    runFrame("dense bottom", LINES, 470, 10, 1, -1, -1, 1'b0);
    runFrame("span", LINES, 0, LINES, 1, -1, -1, 1'b0);

    // Randomized frames, biased toward the screen edges.
    for (int k = 0; k < 8; k++) begin
      h   = int'($urandom_range(1, 60));
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      y = 0;
      else if (sel == 1) y = LINES - h;
      else               y = int'($urandom_range(0, LINES - 1));
      n   = ($urandom_range(0, 4) == 0) ? LINES - 1 : LINES;
      sl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 400)) : -1;
      per = int'($urandom_range(1, 3));
      runFrame($sformatf("rand%0d", k), n, y, h, per, sl, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
